// File: rtl/es9821q_cfg_sequencer.sv
// ES9821Q power-up/reconfiguration sequencer.
// Walks a register table and drives one I2C write per entry, with retry.
module es9821q_cfg_sequencer #(
  parameter int SYS_CLK_FREQ   = 50_000_000,
  parameter int PWR_WAIT_US    = 1000,
  parameter int NUM_REGS       = 4,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 500,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int AUTO_START     = 1
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [3:0] err_idx,
  output logic       i2c_start,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_wr_data,
  input  logic       i2c_done,
  input  logic       i2c_ack
);

  localparam int PWR_RAW = PWR_WAIT_US * (SYS_CLK_FREQ / 1_000_000);
  localparam int PWR_CYC = (PWR_RAW > 0) ? PWR_RAW : 1;
  localparam int GAP_CYC = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int TO_CYC  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
  localparam int MAX_A   = (PWR_CYC > GAP_CYC) ? PWR_CYC : GAP_CYC;
  localparam int MAX_C   = (MAX_A > TO_CYC) ? MAX_A : TO_CYC;
  localparam int CW      = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] PWR_LAST  = CW'(PWR_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [4:0]    IDX_END   = 5'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [4:0]    idx;
  logic [RW-1:0] retry;
  logic          adv;
  logic          auto_pend;

  logic pwr_hit, gap_hit, to_hit;
  logic ok, bad, can_retry;
  logic counting, enter_pwr;

  function automatic logic [15:0] tbl(input logic [4:0] i);
    case (i)
      5'd0:    tbl = 16'h0003;
      5'd1:    tbl = 16'h018C;
      5'd2:    tbl = 16'h0224;
      5'd3:    tbl = 16'h0F00;
      default: tbl = 16'h0000;
    endcase
  endfunction

  assign pwr_hit   = (cnt == PWR_LAST);
  assign gap_hit   = (cnt == GAP_LAST);
  assign to_hit    = (cnt == TO_LAST);
  // A done pulse on the timeout cycle takes precedence over the timeout
  assign ok        = i2c_done & ~i2c_ack;
  assign bad       = (i2c_done & i2c_ack) | (~i2c_done & to_hit);
  assign can_retry = (retry < RETRY_MAX);
  assign counting  = (state == S_PWR) || (state == S_WAIT) || (state == S_GAP);
  assign enter_pwr = (state_n == S_PWR) && (state != S_PWR);
  assign i2c_start = (state == S_ISSUE);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (cfg_start | auto_pend) state_n = S_PWR;
      S_PWR:   if (pwr_hit) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (ok)       state_n = S_GAP;
        else if (bad) state_n = can_retry ? S_GAP : S_ERR;
      end
      S_GAP: begin
        if (gap_hit)
          state_n = (idx == IDX_END) ? S_DONE : S_ISSUE;
      end
      S_DONE,
      S_ERR:   if (cfg_start) state_n = S_PWR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      retry        <= '0;
      adv          <= 1'b0;
      auto_pend    <= (AUTO_START != 0);
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      err_idx      <= '0;
      i2c_reg_addr <= '0;
      i2c_wr_data  <= '0;
    end else begin
      state <= state_n;
      cnt   <= (counting && state_n == state) ? cnt + CW'(1) : '0;

      if (state_n != S_IDLE) auto_pend <= 1'b0;

      if (enter_pwr) begin
        idx      <= '0;
        retry    <= '0;
        adv      <= 1'b0;
        cfg_done <= 1'b0;
        cfg_err  <= 1'b0;
        err_idx  <= '0;
        cfg_busy <= 1'b1;
      end

      if (state == S_WAIT) begin
        if (ok) begin
          idx <= idx + 5'd1;
          adv <= 1'b1;
        end else if (bad) begin
          adv <= 1'b0;
          if (can_retry) retry <= retry + RW'(1);
          else           err_idx <= idx[3:0];
        end
      end

      if (state == S_GAP && state_n == S_ISSUE && adv)
        retry <= '0;

      if (state_n == S_ISSUE && state != S_ISSUE)
        {i2c_reg_addr, i2c_wr_data} <= tbl(idx);

      if (state_n == S_DONE && state != S_DONE) begin
        cfg_done <= 1'b1;
        cfg_busy <= 1'b0;
      end

      if (state_n == S_ERR && state != S_ERR) begin
        cfg_err  <= 1'b1;
        cfg_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_es9821q_cfg_sequencer.sv
// Directed bench for es9821q_cfg_sequencer.
// A behavioural I2C master logs every request and answers per test policy.
module tb_es9821q_cfg_sequencer;

  localparam int GAP = 8;
  localparam int TOC = 1000;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_busy, cfg_done, cfg_err;
  logic [3:0] err_idx;
  logic       i2c_start;
  logic [7:0] i2c_reg_addr, i2c_wr_data;
  logic       i2c_done = 1'b0;
  logic       i2c_ack = 1'b0;

  es9821q_cfg_sequencer #(
    .SYS_CLK_FREQ  (1_000_000),
    .PWR_WAIT_US   (20),
    .NUM_REGS      (4),
    .MAX_RETRY     (3),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TOC),
    .AUTO_START    (1)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .err_idx     (err_idx),
    .i2c_start   (i2c_start),
    .i2c_reg_addr(i2c_reg_addr),
    .i2c_wr_data (i2c_wr_data),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [15:0] EXP [4] = '{16'h0003, 16'h018C, 16'h0224, 16'h0F00};

  int checks = 0;
  int errors = 0;

  int   nack_first [16];
  bit   no_resp = 1'b0;
  int   resp_lat = 3;
  int   att [16];
  logic [15:0] log_q [$];
  int   cyc_q [$];
  int   cyc = 0;
  int   pend_cnt = 0;
  logic pend_ack = 1'b0;

  // Behavioural I2C master: counts attempts per register address
  always @(posedge sys_clk) begin
    if (!rst_n) begin
      i2c_done <= 1'b0;
      i2c_ack  <= 1'b0;
      pend_cnt = 0;
      cyc = 0;
      log_q.delete();
      cyc_q.delete();
      for (int i = 0; i < 16; i++) att[i] = 0;
    end else begin
      cyc = cyc + 1;
      i2c_done <= 1'b0;
      i2c_ack  <= 1'b0;
      if (pend_cnt > 0) begin
        if (pend_cnt == 1) begin
          i2c_done <= 1'b1;
          i2c_ack  <= pend_ack;
        end
        pend_cnt = pend_cnt - 1;
      end
      if (i2c_start) begin
        log_q.push_back({i2c_reg_addr, i2c_wr_data});
        cyc_q.push_back(cyc);
        if (!no_resp) begin
          pend_ack = (att[i2c_reg_addr[3:0]] < nack_first[i2c_reg_addr[3:0]]);
          pend_cnt = resp_lat;
        end
        att[i2c_reg_addr[3:0]] = att[i2c_reg_addr[3:0]] + 1;
      end
    end
  end

  task automatic set_policy(input int lat, input bit nr,
                            input int nk1, input int nk2);
    resp_lat = lat;
    no_resp  = nr;
    for (int i = 0; i < 16; i++) nack_first[i] = 0;
    nack_first[1] = nk1;
    nack_first[2] = nk2;
  endtask

  task automatic do_reset(input int lat, input bit nr,
                          input int nk1, input int nk2);
    @(negedge sys_clk);
    rst_n = 1'b0;
    set_policy(lat, nr, nk1, nk2);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (!cfg_busy && (cfg_done || cfg_err)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (log_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    set_policy(3, 1'b0, 0, 0);
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({cfg_busy, cfg_done, cfg_err, err_idx} !== 7'h0) begin
      errors++;
      $display("FAIL reset_status got %b exp 0",
               {cfg_busy, cfg_done, cfg_err, err_idx});
    end
    checks++;
    if ({i2c_start, i2c_reg_addr, i2c_wr_data} !== 17'h0) begin
      errors++;
      $display("FAIL reset_bus got %h exp 0",
               {i2c_start, i2c_reg_addr, i2c_wr_data});
    end
    rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL auto_start_busy got %b exp 1", cfg_busy);
    end
  endtask

  task automatic test_all_ack;
    bit ok;
    wait_end(1000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL all_ack_finish got timeout exp done");
    end
    checks++;
    if (log_q.size() !== 4) begin
      errors++;
      $display("FAIL all_ack_count got %0d exp 4", log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== EXP[i]) begin
        errors++;
        $display("FAIL all_ack_entry%0d got %h exp %h", i, log_q[i], EXP[i]);
      end
    end
    checks++;
    if (cyc_q.size() < 1 || cyc_q[0] !== 22) begin
      errors++;
      $display("FAIL first_start_cycle got %0d exp 22",
               cyc_q.size() ? cyc_q[0] : -1);
    end
    checks++;
    if ({cfg_done, cfg_busy, cfg_err} !== 3'b100) begin
      errors++;
      $display("FAIL all_ack_status got %b exp 100",
               {cfg_done, cfg_busy, cfg_err});
    end
  endtask

  task automatic test_nack_retry;
    bit ok;
    int n1;
    do_reset(3, 1'b0, 2, 0);
    wait_end(2000, ok);
    n1 = 0;
    foreach (log_q[i]) if (log_q[i][15:8] == 8'h01) n1++;
    checks++;
    if (!ok || {cfg_done, cfg_err} !== 2'b10) begin
      errors++;
      $display("FAIL retry_status got ok=%0d done/err=%b exp 1 10",
               ok, {cfg_done, cfg_err});
    end
    checks++;
    if (n1 !== 3) begin
      errors++;
      $display("FAIL retry_idx1_count got %0d exp 3", n1);
    end
    checks++;
    if (log_q.size() !== 6) begin
      errors++;
      $display("FAIL retry_total got %0d exp 6", log_q.size());
    end
  endtask

  task automatic test_nack_error;
    bit ok;
    int n2, n3;
    do_reset(3, 1'b0, 0, 100);
    wait_end(2000, ok);
    n2 = 0;
    n3 = 0;
    foreach (log_q[i]) begin
      if (log_q[i][15:8] == 8'h02) n2++;
      if (log_q[i][15:8] == 8'h0F) n3++;
    end
    checks++;
    if (!ok || {cfg_err, cfg_done, cfg_busy} !== 3'b100) begin
      errors++;
      $display("FAIL nack_err_status got ok=%0d err/done/busy=%b exp 1 100",
               ok, {cfg_err, cfg_done, cfg_busy});
    end
    checks++;
    if (err_idx !== 4'd2) begin
      errors++;
      $display("FAIL nack_err_idx got %0d exp 2", err_idx);
    end
    checks++;
    if (n2 !== 4) begin
      errors++;
      $display("FAIL nack_idx2_count got %0d exp 4", n2);
    end
    checks++;
    if (n3 !== 0) begin
      errors++;
      $display("FAIL nack_idx3_issued got %0d exp 0", n3);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset(3, 1'b1, 0, 0);
    wait_end(6000, ok);
    checks++;
    if (!ok || cfg_err !== 1'b1 || err_idx !== 4'd0) begin
      errors++;
      $display("FAIL timeout_err got ok=%0d err=%b idx=%0d exp 1 1 0",
               ok, cfg_err, err_idx);
    end
    checks++;
    if (log_q.size() !== 4) begin
      errors++;
      $display("FAIL timeout_attempts got %0d exp 4", log_q.size());
    end
    for (int i = 0; i + 1 < cyc_q.size(); i++) begin
      checks++;
      if (cyc_q[i+1] - cyc_q[i] !== TOC + GAP + 1) begin
        errors++;
        $display("FAIL timeout_spacing%0d got %0d exp %0d",
                 i, cyc_q[i+1] - cyc_q[i], TOC + GAP + 1);
      end
    end
  endtask

  task automatic test_restart;
    bit ok;
    do_reset(3, 1'b0, 0, 0);
    wait_log(2, 500, ok);
    cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
    checks++;
    if (!ok || {cfg_busy, cfg_done} !== 2'b10) begin
      errors++;
      $display("FAIL busy_start_ignored got ok=%0d busy/done=%b exp 1 10",
               ok, {cfg_busy, cfg_done});
    end
    wait_end(1000, ok);
    checks++;
    if (!ok || log_q.size() !== 4 || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_no_restart got %0d entries done=%b exp 4 1",
               log_q.size(), cfg_done);
    end
    @(negedge sys_clk);
    cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
    checks++;
    if ({cfg_done, cfg_busy} !== 2'b01) begin
      errors++;
      $display("FAIL done_restart got done/busy=%b exp 01",
               {cfg_done, cfg_busy});
    end
    wait_end(1000, ok);
    checks++;
    if (!ok || log_q.size() !== 8) begin
      errors++;
      $display("FAIL rerun_count got %0d exp 8", log_q.size());
    end
    for (int i = 4; i < 8 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== EXP[i-4]) begin
        errors++;
        $display("FAIL rerun_entry%0d got %h exp %h", i, log_q[i], EXP[i-4]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset(60, 1'b0, 0, 0);
    wait_log(3, 500, ok);
    checks++;
    if (!ok || log_q[2] !== 16'h0224 || i2c_reg_addr !== 8'h02) begin
      errors++;
      $display("FAIL mid_reach_idx2 got ok=%0d addr=%h exp 1 02",
               ok, i2c_reg_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i2c_start, i2c_reg_addr, i2c_wr_data} !== 17'h0) begin
      errors++;
      $display("FAIL mid_reset_bus got %h exp 0",
               {i2c_start, i2c_reg_addr, i2c_wr_data});
    end
    checks++;
    if ({cfg_busy, cfg_done, cfg_err, err_idx} !== 7'h0) begin
      errors++;
      $display("FAIL mid_reset_status got %b exp 0",
               {cfg_busy, cfg_done, cfg_err, err_idx});
    end
    set_policy(3, 1'b0, 0, 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    wait_end(1000, ok);
    checks++;
    if (!ok || log_q.size() < 1 || log_q[0] !== 16'h0003 || cyc_q[0] !== 22) begin
      errors++;
      $display("FAIL mid_restart got ok=%0d first=%h exp 1 0003 at 22",
               ok, log_q.size() ? log_q[0] : 16'hxxxx);
    end
    checks++;
    if (cfg_done !== 1'b1 || log_q.size() !== 4) begin
      errors++;
      $display("FAIL mid_restart_done got done=%b n=%0d exp 1 4",
               cfg_done, log_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_all_ack;
    test_nack_retry;
    test_nack_error;
    test_timeout;
    test_restart;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
